// File: rtl/dl_pkg.sv
// Shared constants and FSM state type for the ROM download sequencer.
// Holds the download index map and the sequencer state encoding.
package dl_pkg;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DSW = 8'd254;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOADING,
        ST_HOLD,
        ST_RUN
    } dl_state_e;

endpackage

// File: rtl/rom_dl_seq_if.sv
// Download bus: ioctl byte stream in, registered ROM write port out.
// master drives ioctl_* and observes rom_*; slave is the sequencer.
interface rom_dl_seq_if;

    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        rom_we;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;

    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        input  rom_we,
        input  rom_addr,
        input  rom_data
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_index,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        output rom_we,
        output rom_addr,
        output rom_data
    );

endinterface

// File: rtl/rst_hold_timer.sv
// Core reset hold timer: load sets HOLD_CYCLES, tick counts down to 0.
// Ports: clk, rst_n (async low), load, tick in; done out (count reads 1).
module rst_hold_timer #(
    parameter int HOLD_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic done
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 8'(HOLD_CYCLES);
        end else if (tick && cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 8'd1);

endmodule

// File: rtl/rom_dl_seq.sv
// ROM download sequencer: steers ioctl bytes to ROM/DIP/mod and holds
// the game core in reset until a ROM load completes.
// Ports: clk_sys, reset_n, dl (download bus), rst_req; dsw0, mod_super,
// mod_nosuper, core_reset, rom_ok.
module rom_dl_seq
    import dl_pkg::*;
#(
    parameter int ROM_SIZE    = 98304,
    parameter int HOLD_CYCLES = 255
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    rom_dl_seq_if.slave  dl,
    input  logic         rst_req,
    output logic [7:0]   dsw0,
    output logic         mod_super,
    output logic         mod_nosuper,
    output logic         core_reset,
    output logic         rom_ok
);

    localparam logic [17:0] ROM_CNT = 18'(ROM_SIZE);

    dl_state_e        state_q, state_d;
    logic [17:0]      cnt_q, cnt_d;
    logic             rom_ok_q, rom_ok_d;
    logic             rom_we_q, rom_we_d;
    logic [16:0]      rom_addr_q, rom_addr_d;
    logic [7:0]       rom_data_q, rom_data_d;
    logic [7:0][7:0]  dip_q, dip_d;
    logic [7:0]       mod_q, mod_d;
    logic             mod_super_q, mod_super_d;
    logic             mod_nosuper_q, mod_nosuper_d;

    logic rom_sel, start, rom_acc, dsw_acc, mod_acc;
    logic enter_load, exit_load;
    logic tmr_load, tmr_tick, tmr_done;
    logic [17:0] cnt_base;
    logic unused_dip;

    assign rom_sel = (dl.ioctl_index == IDX_ROM);
    assign start   = dl.ioctl_download && rom_sel;
    assign rom_acc = dl.ioctl_wr && rom_sel &&
                     (dl.ioctl_addr < 25'(ROM_SIZE));
    assign dsw_acc = dl.ioctl_wr && (dl.ioctl_index == IDX_DSW) &&
                     (dl.ioctl_addr[24:3] == 22'd0);
    assign mod_acc = dl.ioctl_wr && (dl.ioctl_index == IDX_MOD);

    rst_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .load  (tmr_load),
        .tick  (tmr_tick),
        .done  (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        enter_load = 1'b0;
        exit_load  = 1'b0;
        tmr_load   = 1'b0;
        tmr_tick   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOADING;
                    enter_load = 1'b1;
                end
            end
            ST_LOADING: begin
                if (!dl.ioctl_download) begin
                    state_d   = ST_HOLD;
                    exit_load = 1'b1;
                    tmr_load  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (start) begin
                    state_d    = ST_LOADING;
                    enter_load = 1'b1;
                end else if (rst_req) begin
                    tmr_load = 1'b1;
                end else if (tmr_done) begin
                    state_d  = ST_RUN;
                    tmr_tick = 1'b1;
                end else begin
                    tmr_tick = 1'b1;
                end
            end
            ST_RUN: begin
                if (start) begin
                    state_d    = ST_LOADING;
                    enter_load = 1'b1;
                end else if (rst_req) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The count includes this cycle's write so a strobe on the falling
    // edge of ioctl_download is reflected in rom_ok.
    always_comb begin
        cnt_base = enter_load ? 18'd0 : cnt_q;
        cnt_d    = cnt_base;
        if (rom_acc && cnt_base != ROM_CNT) begin
            cnt_d = cnt_base + 18'd1;
        end
        rom_ok_d = rom_ok_q;
        if (enter_load) begin
            rom_ok_d = 1'b0;
        end else if (exit_load) begin
            rom_ok_d = (cnt_d == ROM_CNT);
        end
    end

    always_comb begin
        rom_we_d      = rom_acc;
        rom_addr_d    = rom_addr_q;
        rom_data_d    = rom_data_q;
        dip_d         = dip_q;
        mod_d         = mod_q;
        mod_super_d   = (mod_q == 8'd0);
        mod_nosuper_d = (mod_q == 8'd1);
        if (rom_acc) begin
            rom_addr_d = dl.ioctl_addr[16:0];
            rom_data_d = dl.ioctl_dout;
        end
        if (dsw_acc) begin
            dip_d[dl.ioctl_addr[2:0]] = dl.ioctl_dout;
        end
        if (mod_acc) begin
            mod_d = dl.ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 18'd0;
            rom_ok_q      <= 1'b0;
            rom_we_q      <= 1'b0;
            rom_addr_q    <= 17'd0;
            rom_data_q    <= 8'd0;
            dip_q         <= '0;
            mod_q         <= 8'd0;
            mod_super_q   <= 1'b1;
            mod_nosuper_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rom_ok_q      <= rom_ok_d;
            rom_we_q      <= rom_we_d;
            rom_addr_q    <= rom_addr_d;
            rom_data_q    <= rom_data_d;
            dip_q         <= dip_d;
            mod_q         <= mod_d;
            mod_super_q   <= mod_super_d;
            mod_nosuper_q <= mod_nosuper_d;
        end
    end

    // DIP bytes 1..7 are stored but not yet exported.
    assign unused_dip = ^dip_q[7:1];

    assign dl.rom_we    = rom_we_q;
    assign dl.rom_addr  = rom_addr_q;
    assign dl.rom_data  = rom_data_q;
    assign dsw0         = dip_q[0];
    assign mod_super    = mod_super_q;
    assign mod_nosuper  = mod_nosuper_q;
    assign core_reset   = (state_q != ST_RUN);
    assign rom_ok       = rom_ok_q;

endmodule

// File: tb/tb_rom_dl_seq.sv
// Scoreboard bench for rom_dl_seq: random download streams, ROM writes
// checked by a negedge monitor, hold timing and side registers inline.
module tb_rom_dl_seq;

    localparam int RS = 2048;
    localparam int HC = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_req = 1'b0;
    logic [7:0] dsw0;
    logic       mod_super, mod_nosuper, core_reset, rom_ok;

    rom_dl_seq_if bus();

    rom_dl_seq #(
        .ROM_SIZE    (RS),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk_sys     (clk),
        .reset_n     (rst_n),
        .dl          (bus),
        .rst_req     (rst_req),
        .dsw0        (dsw0),
        .mod_super   (mod_super),
        .mod_nosuper (mod_nosuper),
        .core_reset  (core_reset),
        .rom_ok      (rom_ok)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         addr;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Monitor: every rom_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.rom_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("rom_we_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rom_addr", 32'(bus.rom_addr), 32'(e.addr));
                check("rom_data", 32'(bus.rom_data), 32'(e.data));
                check("rom_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_rom_we", 32'(bus.rom_we), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_rom_data", 32'(bus.rom_data), 32'd0);
        check("rst_rom_ok", 32'(rom_ok), 32'd0);
        check("rst_dsw0", 32'(dsw0), 32'd0);
        check("rst_mod_super", 32'(mod_super), 32'd1);
        check("rst_mod_nosuper", 32'(mod_nosuper), 32'd0);
    endtask

    // mode 0: leave download high, 1: drop after last byte,
    // 2: drop together with the last byte strobe.
    task automatic download(input int nbytes, input int mode,
                            output int acc);
        acc = 0;
        @(negedge clk);
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'd0;
        for (int i = 0; i < nbytes; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.ioctl_addr = 25'(i);
            bus.ioctl_dout = 8'($urandom);
            bus.ioctl_wr   = 1'b1;
            if (mode == 2 && i == nbytes - 1) bus.ioctl_download = 1'b0;
            if (i < RS) begin
                sb.push_back('{addr: i, data: bus.ioctl_dout, due: cyc + 1});
                acc++;
            end
            @(negedge clk);
            bus.ioctl_wr = 1'b0;
        end
        if (mode == 1) begin
            bus.ioctl_download = 1'b0;
            @(negedge clk);
        end
    endtask

    // Called on the negedge after the edge that entered HOLD (or last
    // reloaded it); counts edges until the core is released.
    task automatic measure_hold(input string name);
        int n;
        n = 0;
        check({name, "_start"}, 32'(core_reset), 32'd1);
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (!core_reset) break;
        end
        check(name, 32'(n), 32'(HC));
    endtask

    task automatic wr_byte(input logic [7:0] idx, input int addr,
                           input logic [7:0] data);
        @(negedge clk);
        bus.ioctl_index = idx;
        bus.ioctl_addr  = 25'(addr);
        bus.ioctl_dout  = data;
        bus.ioctl_wr    = 1'b1;
        @(negedge clk);
        bus.ioctl_wr    = 1'b0;
        bus.ioctl_index = 8'd0;
    endtask

    initial begin
        int acc;
        int bad;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;

        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            rst_req = 1'($urandom);
            if (core_reset !== 1'b1) bad++;
        end
        rst_req = 1'b0;
        check("idle_no_run", 32'(bad), 32'd0);

        download(RS, 2, acc);
        measure_hold("hold_full");
        check("ok_full", 32'(rom_ok), 32'(acc >= RS));

        download(1000, 1, acc);
        measure_hold("hold_short");
        check("ok_short", 32'(rom_ok), 32'(acc >= RS));

        download(RS + 6, 1, acc);
        measure_hold("hold_long");
        check("ok_long", 32'(rom_ok), 32'(acc >= RS));

        wr_byte(8'd254, 0, 8'hA5);
        wr_byte(8'd254, 8, 8'h3C);
        check("dsw0", 32'(dsw0), 32'hA5);
        wr_byte(8'd1, 0, 8'h01);
        check("mod_early_super", 32'(mod_super), 32'd1);
        @(negedge clk);
        check("mod1_super", 32'(mod_super), 32'd0);
        check("mod1_nosuper", 32'(mod_nosuper), 32'd1);
        wr_byte(8'd1, 5, 8'h07);
        @(negedge clk);
        check("mod7_super", 32'(mod_super), 32'd0);
        check("mod7_nosuper", 32'(mod_nosuper), 32'd0);
        wr_byte(8'd7, 3, 8'hFF);
        @(negedge clk);
        check("side_run_kept", 32'(core_reset), 32'd0);
        check("side_ok_kept", 32'(rom_ok), 32'd1);

        @(negedge clk);
        rst_req = 1'b1;
        @(negedge clk);
        rst_req = 1'b0;
        measure_hold("rst_pulse");

        @(negedge clk);
        rst_req = 1'b1;
        repeat (10) @(negedge clk);
        rst_req = 1'b0;
        measure_hold("rst_held10");

        @(negedge clk);
        rst_req = 1'b1;
        repeat ($urandom_range(2, 15)) @(negedge clk);
        rst_req = 1'b0;
        measure_hold("rst_held_rand");

        download(500, 0, acc);
        check("abort_ok_cleared", 32'(rom_ok), 32'd0);
        check("abort_loading", 32'(core_reset), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        check("abort_sb_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_reload_held", 32'(core_reset), 32'd1);
        download(RS, 1, acc);
        measure_hold("hold_reload");
        check("ok_reload", 32'(rom_ok), 32'(acc >= RS));

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rom_dl_seq.md
ROM_DL_SEQ -- requirements
Module: rom_dl_seq

Interface
REQ-001 Parameter ROM_SIZE, default 98304, bytes of program/graphics ROM accepted from download index 0.
REQ-002 Parameter HOLD_CYCLES, default 255, clk_sys cycles core reset is held after a download or reset request (1..255).
REQ-003 clk_sys  in  1  system clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  download session active.
REQ-006 ioctl_index  in  8  download target (0 ROM, 1 mod byte, 254 DIP bytes).
REQ-007 ioctl_wr  in  1  single-cycle byte strobe.
REQ-008 ioctl_addr  in  25  byte address within session.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 rst_req  in  1  soft reset request (menu/button), level.
REQ-011 rom_we  out  1  registered ROM write pulse.
REQ-012 rom_addr  out  17  registered ROM write address.
REQ-013 rom_data  out  8  registered ROM write data.
REQ-014 dsw0  out  8  DIP byte 0.
REQ-015 mod_super / mod_nosuper  out  1 each  game-variant decode.
REQ-016 core_reset  out  1  active-high reset to game core.
REQ-017 rom_ok  out  1  last ROM session delivered at least ROM_SIZE bytes.

Function
REQ-018 FSM states: IDLE, LOADING, HOLD, RUN; core_reset SHALL be 1 in IDLE, LOADING, HOLD and 0 only in RUN.
REQ-019 IDLE -> LOADING when ioctl_download=1 and ioctl_index=0; no other exit from IDLE (core never runs before first ROM load).
REQ-020 RUN or HOLD -> LOADING on the same condition; byte counter and rom_ok cleared on LOADING entry.
REQ-021 LOADING -> HOLD on the first cycle ioctl_download=0; hold counter loaded with HOLD_CYCLES.
REQ-022 HOLD decrements each cycle; HOLD -> RUN on the cycle the counter reads 1 (core_reset high exactly HOLD_CYCLES cycles after LOADING exit).
REQ-023 RUN -> HOLD when rst_req=1, counter reloaded; rst_req in HOLD reloads counter every cycle; rst_req ignored in IDLE and LOADING.
REQ-024 ROM write: ioctl_wr=1, ioctl_index=0, ioctl_addr<ROM_SIZE -> next cycle rom_we=1, rom_addr=ioctl_addr[16:0], rom_data=ioctl_dout; latency exactly 1 cycle; rom_we otherwise 0.
REQ-025 ROM writes with ioctl_addr>=ROM_SIZE SHALL be dropped (no rom_we, no count).
REQ-026 18-bit byte counter increments per accepted ROM write, saturating at ROM_SIZE; on LOADING -> HOLD, rom_ok <= (count==ROM_SIZE).
REQ-027 A write strobe coincident with ioctl_download falling SHALL still be accepted and counted before rom_ok is evaluated.
REQ-028 Index 254, ioctl_addr[24:3]==0: byte stored in DIP register ioctl_addr[2:0]; dsw0 = register 0; no FSM effect.
REQ-029 Index 1: mod byte latched on any write; mod_super=(mod==0), mod_nosuper=(mod==1), registered, valid 1 cycle after the latching cycle; no FSM effect.
REQ-030 Writes with any other index SHALL be ignored.

Reset
REQ-031 reset_n=0 asynchronously forces: state IDLE, core_reset=1, rom_we=0, rom_addr=0, rom_data=0, counters 0, rom_ok=0, all DIP bytes 0, mod=0 (mod_super=1, mod_nosuper=0).
REQ-032 reset_n asserted mid-LOADING aborts the session; after release the FSM waits in IDLE for a new index-0 download even if ioctl_download is still high (re-enters LOADING immediately on the next cycle).

Structure
REQ-033 Shared package dl_pkg SHALL hold IDX_ROM=0, IDX_MOD=1, IDX_DSW=254 and the FSM state enum.
REQ-034 Hold timer SHALL be a separate sub-module rst_hold_timer (load, tick, done).

Verification
REQ-035 Power-up, no download, rst_req toggled -> core_reset stays 1, state IDLE, rom_we never pulses.
REQ-036 Index-0 download of 98304 bytes at addr 0..98303 -> 98304 rom_we pulses each 1 cycle after ioctl_wr with matching addr/data; rom_ok=1; core_reset falls exactly 255 cycles after ioctl_download falls.
REQ-037 Download of 98310 bytes (addr up to 98309) -> last 6 writes produce no rom_we; rom_ok=1; short download of 1000 bytes -> rom_ok=0, core still enters RUN.
REQ-038 Index 254 writes 0xA5 to addr 0, 0x3C to addr 8 -> dsw0=0xA5, addr 8 ignored; index 1 write 0x01 -> mod_super=0, mod_nosuper=1 next cycle; state unchanged.
REQ-039 In RUN, rst_req pulsed 1 cycle -> core_reset high exactly 255 cycles; rst_req held 10 cycles in HOLD -> release 255 cycles after its last high cycle.
REQ-040 reset_n pulsed low mid-LOADING at byte 500 -> all outputs at reset values; new full download completes with rom_ok=1 and RUN reached.
